// File: rtl/eth_pcs_rx_block_sync_mlane.sv
// ---------------------------------------------------------------------------
// eth_pcs_rx_block_sync_mlane
// Multi-lane 64b/66b block-lock engine for the RX PCS. Each lane runs its own
// lock FSM (HUNT / LOCKED / WAIT) on the 2-bit sync header. Every slip is
// followed by a settle period so that the gearbox can realign before headers
// are judged again.
//
// Ports:
//   i_clk          clock
//   i_reset_n      synchronous active-low reset
//   i_valid        per-lane header-valid strobe
//   i_sync_hdr     lane l header at bits [l*W_SYNC +: W_SYNC]
//   i_clr_stat     clears o_lock_lost and o_bad_hdr_cnt
//   o_rx_lock      per-lane block lock (registered)
//   o_slip         per-lane one-beat slip request to gearbox
//   o_all_lock     AND of o_rx_lock
//   o_lock_lost    sticky: lane went from LOCKED to unlocked
//   o_bad_hdr_cnt  per-lane saturating count of invalid headers while LOCKED
// ---------------------------------------------------------------------------
module eth_pcs_rx_block_sync_mlane #(
    parameter int N_LANES        = 4,
    parameter int SH_CNT_MAX     = 64,
    parameter int SH_INVALID_MAX = 16,
    parameter int SLIP_WAIT      = 8,
    parameter int W_ERR_CNT      = 8,
    localparam int W_SYNC        = 2
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic [N_LANES-1:0]             i_valid,
    input  logic [N_LANES*W_SYNC-1:0]      i_sync_hdr,
    input  logic                           i_clr_stat,
    output logic [N_LANES-1:0]             o_rx_lock,
    output logic [N_LANES-1:0]             o_slip,
    output logic                           o_all_lock,
    output logic [N_LANES-1:0]             o_lock_lost,
    output logic [N_LANES*W_ERR_CNT-1:0]   o_bad_hdr_cnt
);

    localparam logic [W_SYNC-1:0] SYNC_CTRL = 2'b10;
    localparam logic [W_SYNC-1:0] SYNC_DATA = 2'b01;

    localparam int SH_W   = $clog2(SH_CNT_MAX);
    localparam int INV_W  = $clog2(SH_INVALID_MAX + 1);
    localparam int WAIT_W = (SLIP_WAIT < 1) ? 1 : $clog2(SLIP_WAIT + 1);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_WAIT   = 2'd2
    } lane_state_t;

    for (genvar l = 0; l < N_LANES; l++) begin : g_lane
        lane_state_t            state_r;
        logic [SH_W-1:0]        sh_cnt_r;
        logic [INV_W-1:0]       inval_cnt_r;
        logic [WAIT_W-1:0]      wait_cnt_r;
        logic                   lock_r;
        logic                   lost_r;
        logic [W_ERR_CNT-1:0]   bad_cnt_r;

        logic [W_SYNC-1:0]      hdr_s;
        logic                   hdr_ok_s;
        logic                   beat_s;
        logic                   last_inval_s;
        logic                   win_end_s;
        logic                   slip_s;
        logic                   bad_inc_s;
        logic                   lost_set_s;

        // Header classification and combinational slip decision for this lane.
        always_comb begin
            hdr_s        = i_sync_hdr[l*W_SYNC +: W_SYNC];
            hdr_ok_s     = (hdr_s == SYNC_CTRL) || (hdr_s == SYNC_DATA);
            beat_s       = i_valid[l];
            last_inval_s = (inval_cnt_r == INV_W'(SH_INVALID_MAX - 1));
            win_end_s    = (sh_cnt_r == SH_W'(SH_CNT_MAX - 1));
            slip_s       = 1'b0;
            // Gated by reset so a lane caught mid-lock never slips while held in reset.
            case (state_r)
                ST_HUNT:   slip_s = i_reset_n & beat_s & ~hdr_ok_s;
                ST_LOCKED: slip_s = i_reset_n & beat_s & ~hdr_ok_s & last_inval_s;
                default:   slip_s = 1'b0;
            endcase
            bad_inc_s  = beat_s & ~hdr_ok_s & (state_r == ST_LOCKED);
            lost_set_s = slip_s & (state_r == ST_LOCKED);
        end

        // Lane lock FSM with its counters and the registered lock flag.
        always_ff @(posedge i_clk) begin
            if (!i_reset_n) begin
                state_r     <= ST_HUNT;
                sh_cnt_r    <= '0;
                inval_cnt_r <= '0;
                wait_cnt_r  <= '0;
                lock_r      <= 1'b0;
            end else if (beat_s) begin
                case (state_r)
                    ST_HUNT: begin
                        if (!hdr_ok_s) begin
                            sh_cnt_r <= '0;
                            if (SLIP_WAIT > 0) begin
                                state_r    <= ST_WAIT;
                                wait_cnt_r <= WAIT_W'(SLIP_WAIT);
                            end
                        end else if (win_end_s) begin
                            state_r     <= ST_LOCKED;
                            lock_r      <= 1'b1;
                            sh_cnt_r    <= '0;
                            inval_cnt_r <= '0;
                        end else begin
                            sh_cnt_r <= sh_cnt_r + SH_W'(1);
                        end
                    end
                    ST_WAIT: begin
                        wait_cnt_r <= wait_cnt_r - WAIT_W'(1);
                        if (wait_cnt_r == WAIT_W'(1)) begin
                            state_r <= ST_HUNT;
                        end
                    end
                    ST_LOCKED: begin
                        // Losing lock takes priority over a window closing on the same beat.
                        if (slip_s) begin
                            state_r     <= (SLIP_WAIT > 0) ? ST_WAIT : ST_HUNT;
                            wait_cnt_r  <= WAIT_W'(SLIP_WAIT);
                            sh_cnt_r    <= '0;
                            inval_cnt_r <= '0;
                            lock_r      <= 1'b0;
                        end else if (win_end_s) begin
                            sh_cnt_r    <= '0;
                            inval_cnt_r <= '0;
                        end else begin
                            sh_cnt_r <= sh_cnt_r + SH_W'(1);
                            if (!hdr_ok_s) begin
                                inval_cnt_r <= inval_cnt_r + INV_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_r <= ST_HUNT;
                        lock_r  <= 1'b0;
                    end
                endcase
            end
        end

        // Statistics: a clear landing with an event keeps that event.
        always_ff @(posedge i_clk) begin
            if (!i_reset_n) begin
                lost_r    <= 1'b0;
                bad_cnt_r <= '0;
            end else if (i_clr_stat) begin
                lost_r    <= lost_set_s;
                bad_cnt_r <= {{(W_ERR_CNT-1){1'b0}}, bad_inc_s};
            end else begin
                if (lost_set_s) begin
                    lost_r <= 1'b1;
                end
                if (bad_inc_s && (bad_cnt_r != {W_ERR_CNT{1'b1}})) begin
                    bad_cnt_r <= bad_cnt_r + W_ERR_CNT'(1);
                end
            end
        end

        assign o_rx_lock[l]                          = lock_r;
        assign o_slip[l]                             = slip_s;
        assign o_lock_lost[l]                        = lost_r;
        assign o_bad_hdr_cnt[l*W_ERR_CNT +: W_ERR_CNT] = bad_cnt_r;
    end

    assign o_all_lock = &o_rx_lock;

endmodule

// File: tb/tb_eth_pcs_rx_block_sync_mlane.sv
// ---------------------------------------------------------------------------
// Self-checking bench for eth_pcs_rx_block_sync_mlane (2 lanes, window 8,
// invalid limit 4, settle 2). A second instance with a 2-bit error counter
// shares the stimulus to exercise counter saturation. A behavioural model
// pushes expected outputs into a queue per beat; they are popped and
// compared after the clock edge.
// ---------------------------------------------------------------------------
module tb_eth_pcs_rx_block_sync_mlane;

    localparam int NL  = 2;
    localparam int SHM = 8;
    localparam int SIM = 4;
    localparam int SW  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  valid = 2'b00;
    logic [3:0]  hdr = 4'b0000;
    logic        clr = 1'b0;

    logic [1:0]  rx_lock, slip, lost;
    logic        all_lock;
    logic [15:0] bad_cnt;
    logic [1:0]  rx_lock2, slip2, lost2;
    logic        all_lock2;
    logic [3:0]  bad_cnt2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    eth_pcs_rx_block_sync_mlane #(
        .N_LANES(NL), .SH_CNT_MAX(SHM), .SH_INVALID_MAX(SIM), .SLIP_WAIT(SW), .W_ERR_CNT(8)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid), .i_sync_hdr(hdr),
        .i_clr_stat(clr), .o_rx_lock(rx_lock), .o_slip(slip), .o_all_lock(all_lock),
        .o_lock_lost(lost), .o_bad_hdr_cnt(bad_cnt)
    );

    eth_pcs_rx_block_sync_mlane #(
        .N_LANES(NL), .SH_CNT_MAX(SHM), .SH_INVALID_MAX(SIM), .SLIP_WAIT(SW), .W_ERR_CNT(2)
    ) dut_sat (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid), .i_sync_hdr(hdr),
        .i_clr_stat(clr), .o_rx_lock(rx_lock2), .o_slip(slip2), .o_all_lock(all_lock2),
        .o_lock_lost(lost2), .o_bad_hdr_cnt(bad_cnt2)
    );

    // Behavioural reference: 0 = hunting, 1 = locked, 2 = settling after a slip.
    int mstate[NL];
    int msh[NL];
    int minv[NL];
    int mwait[NL];
    int mbad[NL];
    int mbad2[NL];
    bit mlost[NL];

    typedef struct {
        logic [1:0] slip;
        logic [1:0] lock;
        logic [1:0] lost;
        logic [7:0] bad0;
        logic [7:0] bad1;
        logic [1:0] sat0;
        logic [1:0] sat1;
    } exp_t;

    exp_t sb_q[$];
    logic [1:0] obs_slip;

    function automatic logic [1:0] good(int i);
        return (i % 2 == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic model_step(input int l, input bit v, input logic [1:0] h,
                              input bit c, input bit rst, output bit s);
        bit bad_hdr;
        bit inc;
        bit setl;
        s = 1'b0;
        inc = 1'b0;
        setl = 1'b0;
        bad_hdr = (h == 2'b00) || (h == 2'b11);
        if (rst) begin
            mstate[l] = 0; msh[l] = 0; minv[l] = 0; mwait[l] = 0;
            mbad[l] = 0; mbad2[l] = 0; mlost[l] = 1'b0;
            return;
        end
        if (v) begin
            if (mstate[l] == 0) begin
                if (bad_hdr) begin
                    s = 1'b1;
                    msh[l] = 0;
                    mstate[l] = 2;
                    mwait[l] = SW;
                end else if (msh[l] == SHM - 1) begin
                    mstate[l] = 1; msh[l] = 0; minv[l] = 0;
                end else begin
                    msh[l]++;
                end
            end else if (mstate[l] == 2) begin
                mwait[l]--;
                if (mwait[l] == 0) mstate[l] = 0;
            end else begin
                inc = bad_hdr;
                if (bad_hdr && minv[l] == SIM - 1) begin
                    s = 1'b1; setl = 1'b1;
                    mstate[l] = 2; mwait[l] = SW; msh[l] = 0; minv[l] = 0;
                end else begin
                    if (bad_hdr) minv[l]++;
                    if (msh[l] == SHM - 1) begin
                        msh[l] = 0; minv[l] = 0;
                    end else begin
                        msh[l]++;
                    end
                end
            end
        end
        if (c) begin
            mbad[l]  = inc ? 1 : 0;
            mbad2[l] = inc ? 1 : 0;
            mlost[l] = setl;
        end else begin
            if (inc && mbad[l] < 255) mbad[l]++;
            if (inc && mbad2[l] < 3) mbad2[l]++;
            if (setl) mlost[l] = 1'b1;
        end
    endtask

    // One beat: drive inputs, push expectations, check slip mid-cycle, then the registered outputs.
    task automatic beat(input logic [1:0] v, input logic [1:0] h0, input logic [1:0] h1,
                        input bit c, input bit rst);
        exp_t e;
        exp_t got;
        bit s;
        @(negedge clk);
        valid = v; hdr = {h1, h0}; clr = c; rst_n = ~rst;
        for (int l = 0; l < NL; l++) begin
            model_step(l, v[l], (l == 0) ? h0 : h1, c, rst, s);
            e.slip[l] = s;
            e.lock[l] = (mstate[l] == 1);
            e.lost[l] = mlost[l];
        end
        e.bad0 = 8'(mbad[0]); e.bad1 = 8'(mbad[1]);
        e.sat0 = 2'(mbad2[0]); e.sat1 = 2'(mbad2[1]);
        sb_q.push_back(e);
        #1;
        obs_slip = slip;
        n_checks++;
        if (slip !== sb_q[0].slip || slip2 !== sb_q[0].slip) begin
            n_errors++;
            $display("FAIL slip: got %b/%b want %b", slip, slip2, sb_q[0].slip);
        end
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        n_checks++;
        if (rx_lock !== got.lock || rx_lock2 !== got.lock || all_lock !== (&got.lock)) begin
            n_errors++;
            $display("FAIL lock: got %b/%b all=%b want %b", rx_lock, rx_lock2, all_lock, got.lock);
        end
        n_checks++;
        if (lost !== got.lost || lost2 !== got.lost) begin
            n_errors++;
            $display("FAIL lock_lost: got %b/%b want %b", lost, lost2, got.lost);
        end
        n_checks++;
        if (bad_cnt !== {got.bad1, got.bad0} || bad_cnt2 !== {got.sat1, got.sat0}) begin
            n_errors++;
            $display("FAIL bad_cnt: got %h/%h want %h/%h", bad_cnt, bad_cnt2,
                     {got.bad1, got.bad0}, {got.sat1, got.sat0});
        end
    endtask

    task automatic lock_lane0();
        for (int i = 0; i < SHM; i++) beat(2'b01, good(i), 2'b00, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        beat(2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
        beat(2'b11, 2'b11, 2'b11, 1'b0, 1'b1);
        n_checks++;
        if (rx_lock !== 2'b00 || all_lock !== 1'b0 || lost !== 2'b00 || bad_cnt !== 16'h0000) begin
            n_errors++;
            $display("FAIL reset_state: got lock=%b lost=%b bad=%h want 0", rx_lock, lost, bad_cnt);
        end
    endtask

    task automatic test_lock_acquire();
        for (int i = 0; i < SHM - 1; i++) beat(2'b01, good(i), 2'b00, 1'b0, 1'b0);
        n_checks++;
        if (rx_lock[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL early_lock: got %b want 0", rx_lock[0]);
        end
        beat(2'b01, good(7), 2'b00, 1'b0, 1'b0);
        n_checks++;
        if (rx_lock !== 2'b01 || all_lock !== 1'b0) begin
            n_errors++;
            $display("FAIL acquire: got lock=%b all=%b want 01/0", rx_lock, all_lock);
        end
    endtask

    task automatic test_hunt_slip();
        logic [3:0] seen;
        beat(2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
        beat(2'b01, 2'b11, 2'b00, 1'b0, 1'b0); seen[0] = obs_slip[0];
        beat(2'b01, 2'b00, 2'b00, 1'b0, 1'b0); seen[1] = obs_slip[0];
        beat(2'b01, 2'b00, 2'b00, 1'b0, 1'b0); seen[2] = obs_slip[0];
        beat(2'b01, 2'b00, 2'b00, 1'b0, 1'b0); seen[3] = obs_slip[0];
        n_checks++;
        if (seen !== 4'b1001) begin
            n_errors++;
            $display("FAIL hunt_slip: got %b want 1001", seen);
        end
    endtask

    task automatic test_locked_errors();
        beat(2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
        lock_lane0();
        for (int w = 0; w < 5; w++) begin
            for (int b = 0; b < SHM; b++)
                beat(2'b01, (b == 1 || b == 3 || b == 5) ? 2'b00 : good(b), 2'b00, 1'b0, 1'b0);
            if (w == 1) begin
                n_checks++;
                if (bad_cnt[7:0] !== 8'd6 || bad_cnt2[1:0] !== 2'd3) begin
                    n_errors++;
                    $display("FAIL saturate: got %0d/%0d want 6/3", bad_cnt[7:0], bad_cnt2[1:0]);
                end
            end
        end
        n_checks++;
        if (rx_lock[0] !== 1'b1 || bad_cnt[7:0] !== 8'd15) begin
            n_errors++;
            $display("FAIL windows: got lock=%b bad=%0d want 1/15", rx_lock[0], bad_cnt[7:0]);
        end
    endtask

    task automatic test_lose_lock();
        for (int b = 0; b < SHM; b++)
            beat(2'b01, (b % 2 == 1) ? 2'b11 : good(b), 2'b00, 1'b0, 1'b0);
        n_checks++;
        if (obs_slip[0] !== 1'b1 || rx_lock[0] !== 1'b0 || lost[0] !== 1'b1 || bad_cnt[7:0] !== 8'd19) begin
            n_errors++;
            $display("FAIL lose_lock: got slip=%b lock=%b lost=%b bad=%0d want 1/0/1/19",
                     obs_slip[0], rx_lock[0], lost[0], bad_cnt[7:0]);
        end
    endtask

    task automatic test_clr_same_beat();
        beat(2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        n_checks++;
        if (lost[0] !== 1'b0 || bad_cnt[7:0] !== 8'd0) begin
            n_errors++;
            $display("FAIL clr_stat: got lost=%b bad=%0d want 0/0", lost[0], bad_cnt[7:0]);
        end
        beat(2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
        beat(2'b01, 2'b11, 2'b00, 1'b0, 1'b0);
        lock_lane0();
        for (int b = 0; b < SHM; b++)
            beat(2'b01, (b % 2 == 1) ? 2'b00 : good(b), 2'b00, (b == SHM - 1), 1'b0);
        n_checks++;
        if (lost[0] !== 1'b1 || bad_cnt[7:0] !== 8'd1 || rx_lock[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL clr_collide: got lost=%b bad=%0d lock=%b want 1/1/0",
                     lost[0], bad_cnt[7:0], rx_lock[0]);
        end
    endtask

    task automatic test_valid_gap();
        beat(2'b01, 2'b01, 2'b00, 1'b0, 1'b0);
        beat(2'b01, 2'b01, 2'b00, 1'b0, 1'b0);
        lock_lane0();
        beat(2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
        beat(2'b01, 2'b01, 2'b00, 1'b0, 1'b0);
        beat(2'b01, 2'b10, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) beat(2'b00, 2'b11, 2'b11, 1'b0, 1'b0);
        n_checks++;
        if (rx_lock[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL gap_hold: got %b want 1", rx_lock[0]);
        end
        for (int b = 3; b < SHM; b++)
            beat(2'b01, (b == 4 || b == 6) ? 2'b00 : good(b), 2'b00, 1'b0, 1'b0);
        for (int b = 0; b < 3; b++) beat(2'b01, 2'b11, 2'b00, 1'b0, 1'b0);
        n_checks++;
        if (rx_lock[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL window_align: got %b want 1", rx_lock[0]);
        end
        beat(2'b01, 2'b11, 2'b00, 1'b0, 1'b0);
        n_checks++;
        if (obs_slip[0] !== 1'b1 || rx_lock[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL gap_slip: got slip=%b lock=%b want 1/0", obs_slip[0], rx_lock[0]);
        end
    endtask

    task automatic test_back_to_back();
        beat(2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < SHM; i++) beat(2'b11, good(i), good(i + 1), 1'b0, 1'b0);
        beat(2'b11, 2'b01, 2'b00, 1'b0, 1'b0);
        n_checks++;
        if (all_lock !== 1'b1 || bad_cnt[15:8] !== 8'd1) begin
            n_errors++;
            $display("FAIL both_lock: got all=%b bad1=%0d want 1/1", all_lock, bad_cnt[15:8]);
        end
        beat(2'b11, 2'b01, 2'b01, 1'b0, 1'b1);
        n_checks++;
        if (rx_lock !== 2'b00 || all_lock !== 1'b0 || lost !== 2'b00 || bad_cnt !== 16'h0000) begin
            n_errors++;
            $display("FAIL mid_reset: got lock=%b lost=%b bad=%h want 0", rx_lock, lost, bad_cnt);
        end
        for (int i = 0; i < SHM - 1; i++) beat(2'b11, good(i), good(i), 1'b0, 1'b0);
        n_checks++;
        if (rx_lock !== 2'b00) begin
            n_errors++;
            $display("FAIL relock_early: got %b want 00", rx_lock);
        end
        beat(2'b11, 2'b10, 2'b01, 1'b0, 1'b0);
        n_checks++;
        if (rx_lock !== 2'b11 || all_lock !== 1'b1) begin
            n_errors++;
            $display("FAIL relock: got %b/%b want 11/1", rx_lock, all_lock);
        end
    endtask

    initial begin
        obs_slip = 2'b00;
        test_reset();
        test_lock_acquire();
        test_hunt_slip();
        test_locked_errors();
        test_lose_lock();
        test_clr_same_beat();
        test_valid_gap();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
